inv_mix_column_seq: RTL and testbench

- Iterative AES InvMixColumns engine for the decryption datapath; the inverse of the forward MixColumn block.
- Captures a 128-bit state as four 32-bit column words and processes COLS_PER_CYCLE columns per clock through a shared GF(2^8) inverse-column datapath.
- Returns the result with a valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the iterative decrypt round.

---
 rtl/inv_mix_column_seq_pkg.sv | 24 ++
 rtl/inv_mix_column_seq_if.sv | 30 +++
 rtl/inv_mix_single_column.sv | 43 ++++
 rtl/inv_mix_column_seq.sv | 98 +++++++++
 tb/tb_inv_mix_column_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/inv_mix_column_seq_pkg.sv
// Shared definitions for the iterative AES InvMixColumns engine: GF(2^8) reduction constant,
// inverse-MixColumns coefficients, the engine FSM state type and the xtime helper.
package inv_mix_column_seq_pkg;

  localparam logic [7:0] GF_POLY_RED = 8'h1B;

  // Inverse MixColumns matrix coefficients (one circulant row: 0e 0b 0d 09).
  localparam logic [7:0] INV_MC_0E = 8'h0E;
  localparam logic [7:0] INV_MC_0B = 8'h0B;
  localparam logic [7:0] INV_MC_0D = 8'h0D;
  localparam logic [7:0] INV_MC_09 = 8'h09;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY_RED : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_column_seq_if.sv
// Handshake and data bundle for inv_mix_column_seq.
//   in_valid/in_ready + S0_in..S3_in : state to transform (column words, [31:24] = row 0)
//   out_valid/out_ready + D0_out..D3_out : transformed state, same byte order
// master: the side that supplies states and consumes results; slave: the engine.
interface inv_mix_column_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] S0_in;
  logic [31:0] S1_in;
  logic [31:0] S2_in;
  logic [31:0] S3_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D0_out;
  logic [31:0] D1_out;
  logic [31:0] D2_out;
  logic [31:0] D3_out;

  modport master (
    output in_valid, S0_in, S1_in, S2_in, S3_in, out_ready,
    input  in_ready, out_valid, D0_out, D1_out, D2_out, D3_out
  );

  modport slave (
    input  in_valid, S0_in, S1_in, S2_in, S3_in, out_ready,
    output in_ready, out_valid, D0_out, D1_out, D2_out, D3_out
  );

endinterface

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column.
//   col_i : input column, [31:24] is row 0, [7:0] is row 3
//   col_o : transformed column, same byte order
// Each byte is expanded once into x, x2, x4, x8; every matrix coefficient is then an XOR of
// the multiples selected by its low four bits.
module inv_mix_single_column
  import inv_mix_column_seq_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] b1 [4];
  logic [7:0] b2 [4];
  logic [7:0] b4 [4];
  logic [7:0] b8 [4];

  function automatic logic [7:0] gf_mul_small(input logic [3:0] c, input logic [7:0] x1,
                                              input logic [7:0] x2, input logic [7:0] x4,
                                              input logic [7:0] x8);
    return ({8{c[0]}} & x1) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign b1[i] = col_i[31-8*i -: 8];
    assign b2[i] = gf_xtime(b1[i]);
    assign b4[i] = gf_xtime(b2[i]);
    assign b8[i] = gf_xtime(b4[i]);
  end

  // Row r applies 0e,0b,0d,09 to rows r, r+1, r+2, r+3 (mod 4): the matrix is circulant.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign col_o[31-8*r -: 8] =
        gf_mul_small(INV_MC_0E[3:0], b1[r],  b2[r],  b4[r],  b8[r])  ^
        gf_mul_small(INV_MC_0B[3:0], b1[R1], b2[R1], b4[R1], b8[R1]) ^
        gf_mul_small(INV_MC_0D[3:0], b1[R2], b2[R2], b4[R2], b8[R2]) ^
        gf_mul_small(INV_MC_09[3:0], b1[R3], b2[R3], b4[R3], b8[R3]);
  end

endmodule

// File: rtl/inv_mix_column_seq.sv
// Iterative AES InvMixColumns engine.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of inv_mix_column_seq_if (state in, result out, valid/ready each way)
// A state is captured in IDLE, COLS_PER_CYCLE columns are transformed per BUSY cycle into the
// result registers, and the result is presented in DONE until out_ready.
module inv_mix_column_seq
  import inv_mix_column_seq_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic                  clk,
  input logic                  rst,
  inv_mix_column_seq_if.slave  bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Both wrap in 2 bits: with 4 columns per cycle the step is 0 and the only column is 0.
  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastCol = 2'(4 - COLS_PER_CYCLE);

  state_e            state_q, state_d;
  logic [1:0]        col_q;
  logic [3:0][31:0]  in_q;
  logic [3:0][31:0]  res_q, res_d;
  logic [1:0]        col_idx [COLS_PER_CYCLE];
  logic [31:0]       col_res [COLS_PER_CYCLE];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = BUSY;
      BUSY:    if (col_q == LastCol) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_idx[k] = col_q + 2'(k);
    inv_mix_single_column u_col (
      .col_i (in_q[col_idx[k]]),
      .col_o (col_res[k])
    );
  end

  always_comb begin
    res_d = res_q;
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      res_d[col_idx[k]] = col_res[k];
    end
  end

  // Datapath registers; the result registers move only in BUSY so D*_out hold in IDLE/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      in_q  <= '0;
      res_q <= '0;
    end else if (state_q == IDLE && bus.in_valid) begin
      col_q <= '0;
      in_q  <= {bus.S3_in, bus.S2_in, bus.S1_in, bus.S0_in};
    end else if (state_q == BUSY) begin
      col_q <= col_q + ColStep;
      res_q <= res_d;
    end
  end

  assign bus.D0_out = res_q[0];
  assign bus.D1_out = res_q[1];
  assign bus.D2_out = res_q[2];
  assign bus.D3_out = res_q[3];

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Directed bench for inv_mix_column_seq: three engines (1, 2 and 4 columns per cycle) are
// driven in lockstep with the same states and checked against hand-computed vectors and a
// forward MixColumns model (round trip).
module tb_inv_mix_column_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  inv_mix_column_seq_if bus1 ();
  inv_mix_column_seq_if bus2 ();
  inv_mix_column_seq_if bus4 ();

  inv_mix_column_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  inv_mix_column_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  inv_mix_column_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  wire [127:0] d1 = {bus1.D0_out, bus1.D1_out, bus1.D2_out, bus1.D3_out};
  wire [127:0] d2 = {bus2.D0_out, bus2.D1_out, bus2.D2_out, bus2.D3_out};
  wire [127:0] d4 = {bus4.D0_out, bus4.D1_out, bus4.D2_out, bus4.D3_out};
  wire [2:0]   ov = {bus1.out_valid, bus2.out_valid, bus4.out_valid};
  wire [2:0]   ir = {bus1.in_ready, bus2.in_ready, bus4.in_ready};

  localparam logic [127:0] FipsIn  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] FipsOut = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  // Forward MixColumns model, used to build round-trip stimulus.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [127:0] st);
    bus1.in_valid = v;
    bus1.S0_in = st[127:96];
    bus1.S1_in = st[95:64];
    bus1.S2_in = st[63:32];
    bus1.S3_in = st[31:0];
    bus2.in_valid = v;
    bus2.S0_in = st[127:96];
    bus2.S1_in = st[95:64];
    bus2.S2_in = st[63:32];
    bus2.S3_in = st[31:0];
    bus4.in_valid = v;
    bus4.S0_in = st[127:96];
    bus4.S1_in = st[95:64];
    bus4.S2_in = st[63:32];
    bus4.S3_in = st[31:0];
  endtask

  task automatic set_ordy(input logic v);
    bus1.out_ready = v;
    bus2.out_ready = v;
    bus4.out_ready = v;
  endtask

  task automatic chk_data(input string tag, input logic [127:0] exp);
    chk({tag, "_d1"}, d1, exp);
    chk({tag, "_d2"}, d2, exp);
    chk({tag, "_d4"}, d4, exp);
  endtask

  // Called just after the accept edge; the accept edge counts as edge 1.
  task automatic wait_done(output int l1, output int l2, output int l4);
    l1 = 0;
    l2 = 0;
    l4 = 0;
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk); #1;
      if (l1 == 0 && bus1.out_valid) l1 = k;
      if (l2 == 0 && bus2.out_valid) l2 = k;
      if (l4 == 0 && bus4.out_valid) l4 = k;
      if (l1 != 0 && l2 != 0 && l4 != 0) break;
    end
  endtask

  task automatic run_txn(input logic [127:0] st, input logic [127:0] exp, input int stall,
                         input string tag);
    int l1, l2, l4;
    set_in(1'b1, st);
    chk({tag, "_accept_rdy"}, 128'(ir), 128'(3'b111));
    @(posedge clk); #1;
    set_in(1'b0, 128'h0);
    wait_done(l1, l2, l4);
    chk({tag, "_lat1"}, 128'(l1), 128'd5);
    chk({tag, "_lat2"}, 128'(l2), 128'd3);
    chk({tag, "_lat4"}, 128'(l4), 128'd2);
    chk_data(tag, exp);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_stat"}, 128'({ov, ir}), 128'(6'b111000));
      chk_data({tag, "_hold"}, exp);
    end
    set_ordy(1'b1);
    @(posedge clk); #1;
    set_ordy(1'b0);
    chk({tag, "_release"}, 128'({ov, ir}), 128'(6'b000111));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fixed_vecs [3];
    logic [127:0] x;
    fixed_vecs[0] = {4{32'h01010101}};
    fixed_vecs[1] = {4{32'hc6c6c6c6}};
    fixed_vecs[2] = 128'h0;

    set_in(1'b1, FipsIn);  // in_valid high during reset must be ignored
    set_ordy(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(1'b0, 128'h0);
    chk("reset_stat", 128'({ov, ir}), 128'(6'b000111));
    chk_data("reset", 128'h0);

    run_txn(FipsIn, FipsOut, 0, "fips");
    chk_data("idle_keep", FipsOut);

    for (int i = 0; i < 3; i++) run_txn(fixed_vecs[i], fixed_vecs[i], 1, "fixed");

    x = 128'h00112233_44556677_8899aabb_ccddeeff;
    run_txn(fwd(x), x, 10, "backpressure");

    // New data with in_valid held high during BUSY/DONE must be ignored.
    set_in(1'b1, FipsIn);
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      set_in(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()});
      chk("chg_busy_rdy", 128'(ir), 128'(3'b000));
      @(posedge clk); #1;
    end
    chk("chg_done", 128'(ov), 128'(3'b111));
    chk_data("chg", FipsOut);
    set_ordy(1'b1);
    @(posedge clk); #1;
    set_ordy(1'b0);
    chk("chg_idle", 128'({ov, ir}), 128'(6'b000111));
    chk_data("chg_idle", FipsOut);
    set_in(1'b0, 128'h0);
    @(posedge clk); #1;

    // Reset after the 1-column engine has written two columns.
    set_in(1'b1, fwd(x));
    @(posedge clk); #1;
    set_in(1'b0, 128'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_stat", 128'({ov, ir}), 128'(6'b000111));
    chk_data("midrst", 128'h0);
    run_txn(FipsIn, FipsOut, 0, "after_rst");

    for (int t = 0; t < 1000; t++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_txn(fwd(x), x, int'($urandom_range(0, 3)), "roundtrip");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
